key_entry: RTL and testbench
============================

Name: key_entry

Overview:
- Input front end for the 4-digit code-lock alarm FSM.
- Conditions raw board inputs: three digit switches, an ENTER button and a MODE button.
- Delivers one clean, single-cycle-qualified 3-bit digit per ENTER press, plus the program/arm select level.
- Tracks the position within the 4-digit sequence and aborts a partial entry after an inactivity timeout.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required before a button's debounced level changes (>=2)
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before the partial entry is aborted (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
sw  input  3  raw digit switches, asynchronous to clk
btn_enter  input  1  raw ENTER button, active-high, bouncy
btn_mode  input  1  raw MODE button, active-high, bouncy
digit  output  3  captured digit, held until next capture
digit_valid  output  1  one-cycle pulse, digit is new this cycle
sel  output  1  program-mode level; 1 = code programming, 0 = check
entry_idx  output  2  index of the next digit expected (0..3)
timeout  output  1  one-cycle pulse, partial entry aborted

Behaviour:
- Reset (async assert, sync deassert via 2-FF): digit=0, digit_valid=0, sel=0, entry_idx=0, timeout=0, FSM=IDLE, debouncers low, counters 0.
- Synchronizers: sw, btn_enter and btn_mode each pass through a 2-FF synchronizer. sw is a 3-bit bus; it is captured only at an ENTER event, and the operator must hold it stable.
- Debounce per button:
  - Counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments; on reaching DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - Event = debounced rising edge, registered.
- Latency: raw ENTER high first sampled at edge k → digit_valid high during the cycle after edge k+DEBOUNCE_CYCLES+2, for exactly one cycle. MODE events have the same latency.
- ENTER event:
  - digit <= synchronized sw; digit_valid=1 for one cycle.
  - entry_idx increments, wrapping 3→0.
  - FSM: IDLE→COLLECT when the new idx != 0; COLLECT→IDLE when idx wraps to 0.
- MODE event:
  - sel toggles; entry_idx <= 0; FSM→IDLE; idle counter cleared.
  - No digit_valid is produced.
- Simultaneous ENTER and MODE events in the same cycle: MODE wins, ENTER is dropped (no digit_valid, digit unchanged).
- Timeout:
  - In COLLECT, the idle counter counts cycles with no event.
  - On reaching TIMEOUT_CYCLES-1: timeout=1 for one cycle, entry_idx <= 0, FSM→IDLE, counter cleared.
  - The counter is held at 0 in IDLE and cleared by any event.
  - An ENTER event in the same cycle as timeout expiry: ENTER wins, timeout is suppressed.
- Held button produces exactly one event; release produces no event.
- Reset mid-entry: all outputs return to reset values immediately; no pulse is emitted on reset release.
- Widths: idle counter $clog2(TIMEOUT_CYCLES), debounce counter $clog2(DEBOUNCE_CYCLES); both saturate-free by construction.

Decomposition:
- Shared package alarm_pkg holds:
  - DIGIT_W=3 and NUM_DIGITS=4.
  - State typedef key_entry_state_t {IDLE, COLLECT}.
  - The default DEBOUNCE_CYCLES / TIMEOUT_CYCLES constants.
- One natural sub-module: btn_debounce (2-FF sync + debounce counter + rising-edge pulse), parameterised by DEBOUNCE_CYCLES, instantiated twice.

Test Plan:
1. DEBOUNCE_CYCLES=4: reset, sw=3'd5, btn_enter high with 3 bounces of 2 cycles, then stable 20 cycles → exactly one digit_valid pulse, digit=5, entry_idx 0→1, pulse 7 cycles after the first stable sample.
2. Four clean ENTER presses with sw=1,2,3,4 → four digit_valid pulses with digit 1,2,3,4; entry_idx 1,2,3,0; FSM back to IDLE; timeout never pulses.
3. TIMEOUT_CYCLES=50: two presses, then idle 60 cycles → single timeout pulse exactly 50 cycles after the last event; entry_idx=0; no further pulses.
4. MODE press mid-entry (idx=2) → sel 0→1, entry_idx=0, no digit_valid; second MODE press → sel=0.
5. ENTER and MODE debounced edges aligned to the same cycle → sel toggles, no digit_valid, digit unchanged; ENTER landing on the timeout-expiry cycle → digit_valid, no timeout.
6. rst_n pulsed low for 1 ns mid-debounce and mid-entry → outputs 0 immediately; button held through reset release produces no event until released and pressed again.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared constants and types for the code-lock alarm front end.
package alarm_pkg;

    localparam int DIGIT_W    = 3;
    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 1000;

    typedef enum logic {
        IDLE,
        COLLECT
    } key_entry_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, stability counter and registered rising-edge event.
module btn_debounce
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_event
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [1:0]       vld_q, vld_d;
    logic             armed_q, armed_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        sync_d  = {sync_q[0], btn_raw};
        vld_d   = {vld_q[0], 1'b1};
        level_d = level_q;
        cnt_d   = cnt_q;

        // A button held through reset must be seen released before it can fire.
        armed_d = armed_q | (vld_q[1] & ~sync_q[1]);

        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        evt_d = armed_q & level_d & ~level_q;
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            armed_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            vld_q   <= vld_d;
            armed_q <= armed_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
        end
    end

    assign btn_event = evt_q;

endmodule

// File: rtl/key_entry.sv
// Key-entry front end: conditions digit switches and ENTER/MODE buttons into
// qualified digits, a program-mode select and an inactivity abort.
module key_entry
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] sw,
    input  logic               btn_enter,
    input  logic               btn_mode,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    output logic               sel,
    output logic [IDX_W-1:0]   entry_idx,
    output logic               timeout
);

    localparam int                 IDLE_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               rst_int_n;
    logic [DIGIT_W-1:0] sw_meta_q, sw_sync_q;
    logic               enter_evt, mode_evt;

    key_entry_state_t   state_q, state_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               sel_q, sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic               timeout_q, timeout_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

    // Reset asserts immediately and releases two clocks later, glitch-free.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .btn_raw  (btn_enter),
        .btn_event(enter_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk      (clk),
        .rst_n    (rst_int_n),
        .btn_raw  (btn_mode),
        .btn_event(mode_evt)
    );

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        valid_d    = 1'b0;
        sel_d      = sel_q;
        idx_d      = idx_q;
        timeout_d  = 1'b0;
        idle_cnt_d = idle_cnt_q;

        // MODE beats ENTER, and any event beats an expiring idle counter.
        if (mode_evt) begin
            sel_d      = ~sel_q;
            idx_d      = '0;
            state_d    = IDLE;
            idle_cnt_d = '0;
        end else if (enter_evt) begin
            digit_d    = sw_sync_q;
            valid_d    = 1'b1;
            idx_d      = idx_inc;
            state_d    = (idx_inc == '0) ? IDLE : COLLECT;
            idle_cnt_d = '0;
        end else if (state_q == COLLECT) begin
            if (idle_cnt_q == IDLE_LAST) begin
                timeout_d  = 1'b1;
                idx_d      = '0;
                state_d    = IDLE;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            digit_q    <= '0;
            valid_q    <= 1'b0;
            sel_q      <= 1'b0;
            idx_q      <= '0;
            timeout_q  <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            timeout_q  <= timeout_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign sel         = sel_q;
    assign entry_idx   = idx_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry with short debounce and timeout windows.
module tb_key_entry;

    localparam int D = 4;
    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] sw = 3'd0;
    logic       btn_enter = 1'b0;
    logic       btn_mode = 1'b0;
    logic [2:0] digit;
    logic       digit_valid;
    logic       sel;
    logic [1:0] entry_idx;
    logic       timeout;

    always #5 clk = ~clk;

    key_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .btn_enter  (btn_enter),
        .btn_mode   (btn_mode),
        .digit      (digit),
        .digit_valid(digit_valid),
        .sel        (sel),
        .entry_idx  (entry_idx),
        .timeout    (timeout)
    );

    typedef struct packed {
        logic [2:0] digit;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_timeout = 0;
    int last_valid_cyc = -1;
    int last_timeout_cyc = -1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // One clock: sample on the falling edge and retire scoreboard entries.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (digit_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_digit_valid: got digit=%0d idx=%0d at cycle %0d, expected no pulse",
                             digit, entry_idx, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ({digit, entry_idx} !== {e.digit, e.idx}) begin
                        miscompares++;
                        $display("FAIL digit_capture: got digit=%0d idx=%0d, expected digit=%0d idx=%0d",
                                 digit, entry_idx, e.digit, e.idx);
                    end
                end
            end
            if (timeout === 1'b1) begin
                n_timeout++;
                last_timeout_cyc = cyc;
            end
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn_enter = 1'b0;
        btn_mode = 1'b0;
        sw = 3'd0;
        ticks(3);
        rst_n = 1'b1;
        ticks(6);
    endtask

    task automatic press_enter(input logic [2:0] v, input logic [1:0] idx);
        exp_t e;
        e.digit = v;
        e.idx = idx;
        exp_q.push_back(e);
        sw = v;
        btn_enter = 1'b1;
        ticks(10);
        btn_enter = 1'b0;
        ticks(10);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        ticks(10);
        btn_mode = 1'b0;
        ticks(10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(2);
        vectors++;
        if ({digit, digit_valid, sel, entry_idx, timeout} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected all zero", {digit, digit_valid, sel, entry_idx, timeout});
        end
        rst_n = 1'b1;
        ticks(8);
        vectors++;
        if ({digit, sel, entry_idx} !== 6'd0 || n_valid != 0 || n_timeout != 0) begin
            miscompares++;
            $display("FAIL reset_release: got digit=%0d sel=%0d idx=%0d pulses=%0d/%0d, expected all zero",
                     digit, sel, entry_idx, n_valid, n_timeout);
        end
    endtask

    task automatic test_bounce();
        int n0, drv;
        exp_t e;
        do_reset();
        n0 = n_valid;
        sw = 3'd5;
        repeat (3) begin
            btn_enter = 1'b1;
            ticks(2);
            btn_enter = 1'b0;
            ticks(2);
        end
        e.digit = 3'd5;
        e.idx = 2'd1;
        exp_q.push_back(e);
        btn_enter = 1'b1;
        drv = cyc;
        ticks(20);
        btn_enter = 0;
        ticks(10);
        vectors++;
        if (n_valid - n0 != 1) begin
            miscompares++;
            $display("FAIL bounce_pulse_count: got %0d pulses, expected 1", n_valid - n0);
        end
        vectors++;
        if (last_valid_cyc != drv + D + 3) begin
            miscompares++;
            $display("FAIL bounce_latency: got pulse at cycle %0d, expected %0d", last_valid_cyc, drv + D + 3);
        end
        vectors++;
        if (digit !== 3'd5 || entry_idx !== 2'd1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bounce_hold: got digit=%0d idx=%0d pending=%0d, expected 5 1 0",
                     digit, entry_idx, exp_q.size());
        end
    endtask

    task automatic test_four_digits();
        int n0, t0;
        do_reset();
        n0 = n_valid;
        t0 = n_timeout;
        for (int i = 1; i <= 4; i++) press_enter(3'(i), 2'(i % 4));
        ticks(60);
        vectors++;
        if (n_valid - n0 != 4 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL four_digits_count: got %0d pulses pending=%0d, expected 4 and 0", n_valid - n0, exp_q.size());
        end
        vectors++;
        if (entry_idx !== 2'd0 || n_timeout != t0) begin
            miscompares++;
            $display("FAIL four_digits_wrap: got idx=%0d timeouts=%0d, expected idx=0 timeouts=0",
                     entry_idx, n_timeout - t0);
        end
    endtask

    task automatic test_timeout();
        int t0, v;
        do_reset();
        t0 = n_timeout;
        press_enter(3'd1, 2'd1);
        press_enter(3'd2, 2'd2);
        v = last_valid_cyc;
        ticks(60);
        vectors++;
        if (n_timeout - t0 != 1) begin
            miscompares++;
            $display("FAIL timeout_count: got %0d pulses, expected 1", n_timeout - t0);
        end
        vectors++;
        if (last_timeout_cyc != v + T) begin
            miscompares++;
            $display("FAIL timeout_latency: got cycle %0d, expected %0d", last_timeout_cyc, v + T);
        end
        vectors++;
        if (entry_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL timeout_idx: got %0d, expected 0", entry_idx);
        end
        ticks(60);
        vectors++;
        if (n_timeout - t0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_quiet: got %0d pulses pending=%0d, expected 1 and 0", n_timeout - t0, exp_q.size());
        end
    endtask

    task automatic test_mode();
        int n0;
        do_reset();
        press_enter(3'd1, 2'd1);
        press_enter(3'd2, 2'd2);
        n0 = n_valid;
        press_mode();
        vectors++;
        if (sel !== 1'b1 || entry_idx !== 2'd0 || n_valid != n0) begin
            miscompares++;
            $display("FAIL mode_first: got sel=%0d idx=%0d extra=%0d, expected 1 0 0", sel, entry_idx, n_valid - n0);
        end
        press_mode();
        vectors++;
        if (sel !== 1'b0 || n_valid != n0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL mode_second: got sel=%0d extra=%0d, expected 0 0", sel, n_valid - n0);
        end
    endtask

    task automatic test_simultaneous();
        int n0, t0, v, m;
        do_reset();
        press_enter(3'd3, 2'd1);
        n0 = n_valid;
        sw = 3'd6;
        btn_enter = 1'b1;
        btn_mode = 1'b1;
        ticks(10);
        btn_enter = 1'b0;
        btn_mode = 1'b0;
        ticks(10);
        vectors++;
        if (sel !== 1'b1 || digit !== 3'd3 || entry_idx !== 2'd0 || n_valid != n0) begin
            miscompares++;
            $display("FAIL mode_beats_enter: got sel=%0d digit=%0d idx=%0d extra=%0d, expected 1 3 0 0",
                     sel, digit, entry_idx, n_valid - n0);
        end

        press_enter(3'd6, 2'd1);
        v = last_valid_cyc;
        t0 = n_timeout;
        m = v + T - D - 3;
        while (cyc < m) tick();
        exp_q.push_back(exp_t'({3'd7, 2'd2}));
        sw = 3'd7;
        btn_enter = 1'b1;
        ticks(10);
        btn_enter = 1'b0;
        ticks(10);
        vectors++;
        if (last_valid_cyc != v + T || n_timeout != t0 || entry_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL enter_beats_timeout: got pulse cycle=%0d timeouts=%0d idx=%0d, expected %0d 0 2",
                     last_valid_cyc, n_timeout - t0, entry_idx, v + T);
        end
        ticks(45);
        vectors++;
        if (n_timeout != t0 + 1 || last_timeout_cyc != v + 2 * T) begin
            miscompares++;
            $display("FAIL timeout_after_collision: got %0d pulses at cycle %0d, expected 1 at %0d",
                     n_timeout - t0, last_timeout_cyc, v + 2 * T);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset();
        press_mode();
        press_enter(3'd1, 2'd1);
        sw = 3'd2;
        btn_enter = 1'b1;
        ticks(3);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({digit, digit_valid, sel, entry_idx, timeout} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b, expected all zero", {digit, digit_valid, sel, entry_idx, timeout});
        end
        rst_n = 1'b1;
        n0 = n_valid;
        ticks(30);
        vectors++;
        if (n_valid != n0 || entry_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL held_through_reset: got %0d pulses idx=%0d, expected 0 0", n_valid - n0, entry_idx);
        end
        btn_enter = 1'b0;
        ticks(10);
        press_enter(3'd2, 2'd1);
        vectors++;
        if (n_valid != n0 + 1 || digit !== 3'd2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL repress_after_reset: got %0d pulses digit=%0d pending=%0d, expected 1 2 0",
                     n_valid - n0, digit, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_four_digits();
        test_timeout();
        test_mode();
        test_simultaneous();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
